sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO for general buffering between producer and consumer logic in the same clock domain.
- Supports arbitrary (non-power-of-two) depth and configurable data width.
- Selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Provides occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer)
FWFT, 0, 0 = standard read (data_out updates 1 cycle after accepted read); 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
CNT_WIDTH, $clog2(DEPTH+1), width of count output (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of pointers, count and error flags
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read request (FWFT: pop of head entry)
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CNT_WIDTH  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
Reset and acceptance:
- Reset (async assert, sync deassert by the system): wr_idx = 0, rd_idx = 0, count = 0, data_out = 0, overflow = 0, underflow = 0. Consequently empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0). Memory contents are not reset.
- Write accepted iff w_en && !full. The entry is stored at wr_idx, and wr_idx advances with explicit wrap: DEPTH-1 -> 0.
- Read accepted iff r_en && !empty. rd_idx advances with the same wrap rule.
- full/empty come from the registered count. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.

Count and flags:
- count next = count + wr_acc - rd_acc. A simultaneous accepted read and write leaves count unchanged.
- All flags are combinational decodes of the registered count.

Error flags:
- overflow sets on w_en && full; underflow sets on r_en && empty.
- Both hold until flush or reset.
- A rejected access changes no pointer, no count and no data_out.

Read data:
- FWFT=0: on an accepted read, data_out <= mem[rd_idx] at the same edge. Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_idx] combinationally. It is valid whenever !empty and undefined-but-stable when empty. A word written into an empty FIFO is visible on data_out the cycle after the write edge.

Flush:
- At the edge where flush = 1, pointers, count, overflow and underflow go to 0.
- data_out (FWFT=0) holds its value.
- w_en/r_en in the flush cycle are ignored.
- flush has priority over all other operations.

Reset mid-operation:
- All state clears immediately. The first access after reset behaves as on an empty FIFO.

Optional Feature:
Macro SYNC_FIFO_WATERMARK_EN.
- Defined: adds output port max_count [CNT_WIDTH], a registered peak occupancy.
  - Updates to count_next whenever count_next > max_count.
  - Cleared by reset and by flush.
- Undefined: the port and register are absent. No other behaviour changes.

Decomposition:
- Package sync_fifo_pkg: read-mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1, plus the function for deriving the count width.
- One sub-module, sync_fifo_ptr: a wrap-around index counter parametrised by DEPTH with an increment enable and flush input. It is instantiated twice (write and read).
- Storage is inferred inline as a register array with no reset.

Test Plan:
- DEPTH=5, FWFT=0: write 0x11..0x15 -> full=1, count=5, almost_full=1. A 6th write sets overflow=1 and count stays 5. Five reads return 0x11..0x15 in order, each one cycle after r_en, then empty=1.
- DEPTH=5 wrap: fill 3, read 3, repeat 4 times with incrementing data -> indices wrap past 4, data order preserved, count never exceeds 3.
- Simultaneous: at count=2, assert w_en and r_en for 10 cycles -> count stays 2, no errors. At count=5 (full), w_en+r_en -> read accepted, write rejected, overflow=1, count=4.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0 and data_out=0xA5 with no r_en. r_en pops it -> empty=1. r_en while empty -> underflow=1.
- Flush with count=3, overflow=1 -> next cycle count=0, empty=1, overflow=0, and a write issued in the flush cycle is not stored.
- Async reset asserted mid-burst (count=4) -> outputs reach reset values without a clock edge. After release, a single write/read round-trips correctly. With SYNC_FIFO_WATERMARK_EN, max_count=4 before reset and 0 after.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode constants and width helpers.
// The optional watermark output is enabled by defining SYNC_FIFO_WATERMARK_EN.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy ranges over 0..DEPTH inclusive, hence DEPTH+1 values.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_idx_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrap-around index counter for the FIFO: steps 0..DEPTH-1 and wraps explicitly,
// so non-power-of-two depths work.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IDX_WIDTH = fifo_idx_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 inc,
  output logic [IDX_WIDTH-1:0] idx
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  logic [IDX_WIDTH-1:0] idx_reg;
  logic [IDX_WIDTH-1:0] idx_next;

  always_comb begin
    idx_next = idx_reg;
    if (flush) begin
      idx_next = '0;
    end else if (inc) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  assign idx = idx_reg;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, level flags,
// sticky error flags and flush. Define SYNC_FIFO_WATERMARK_EN to add max_count.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CNT_WIDTH  = fifo_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
`ifdef SYNC_FIFO_WATERMARK_EN
  ,
  output logic [CNT_WIDTH-1:0]  max_count
`endif
);

  localparam int IDX_WIDTH = fifo_idx_width(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_CNT    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_CNT    = CNT_WIDTH'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_WIDTH-1:0] wr_idx;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 overflow_reg;
  logic                 overflow_next;
  logic                 underflow_reg;
  logic                 underflow_next;

  // Acceptance is judged on the registered count, so a same-cycle read never
  // makes room for a write into a full FIFO (and vice versa when empty).
  assign wr_acc = w_en && !full  && !flush;
  assign rd_acc = r_en && !empty && !flush;

  always_comb begin
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush) begin
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count_next = count_reg + CNT_WIDTH'(1);
      end else if (rd_acc && !wr_acc) begin
        count_next = count_reg - CNT_WIDTH'(1);
      end
      if (w_en && full) begin
        overflow_next = 1'b1;
      end
      if (r_en && empty) begin
        underflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  sync_fifo_ptr #(
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (wr_acc),
    .idx   (wr_idx)
  );

  sync_fifo_ptr #(
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (rd_acc),
    .idx   (rd_idx)
  );

  // Storage carries no reset so it maps onto plain RAM/register resources.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_idx] <= data_in;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign data_out = mem[rd_idx];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_out_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_reg <= '0;
        end else if (rd_acc) begin
          data_out_reg <= mem[rd_idx];
        end
      end

      assign data_out = data_out_reg;
    end
  endgenerate

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CNT_WIDTH-1:0] max_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_count_reg <= '0;
    end else if (flush) begin
      max_count_reg <= '0;
    end else if (count_next > max_count_reg) begin
      max_count_reg <= count_next;
    end
  end

  assign max_count = max_count_reg;
`endif

  assign count        = count_reg;
  assign full         = (count_reg == DEPTH_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a standard-read and an FWFT instance (DEPTH=5) share
// stimulus and are checked against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int DW  = 8;
  localparam int DEP = 5;
  localparam int CW  = 3;
  localparam int AF  = DEP - 2;
  localparam int AE  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          w_en;
  logic [DW-1:0] data_in;
  logic          r_en;

  logic [DW-1:0] dout_s, dout_f;
  logic          full_s, full_f, empty_s, empty_f;
  logic          af_s, af_f, ae_s, ae_f;
  logic [CW-1:0] count_s, count_f;
  logic          ovf_s, ovf_f, udf_s, udf_f;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CW-1:0] maxc_s, maxc_f;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_udf;
  int            peak;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(0)) u_std (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (dout_s),
    .full         (full_s),
    .empty        (empty_s),
    .almost_full  (af_s),
    .almost_empty (ae_s),
    .count        (count_s),
    .overflow     (ovf_s),
    .underflow    (udf_s)
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    .max_count    (maxc_s)
`endif
  );

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEP), .FWFT(1)) u_fwft (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (dout_f),
    .full         (full_f),
    .empty        (empty_f),
    .almost_full  (af_f),
    .almost_empty (ae_f),
    .count        (count_f),
    .overflow     (ovf_f),
    .underflow    (udf_f)
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    .max_count    (maxc_f)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic clr_dout);
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    peak    = 0;
    if (clr_dout) exp_dout = '0;
  endtask

  // One clock edge of the FIFO rules, evaluated on the pre-edge occupancy.
  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEP);
    was_empty = (q.size() == 0);
    if (f) begin
      model_clear(1'b0);
    end else begin
      if (w && was_full)  exp_ovf = 1'b1;
      if (r && was_empty) exp_udf = 1'b1;
      if (r && !was_empty) exp_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (q.size() > peak) peak = q.size();
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("count",        32'(count_s), 32'(n));
    check("count_fwft",   32'(count_f), 32'(n));
    check("full",         32'(full_s),  32'(n == DEP));
    check("empty",        32'(empty_s), 32'(n == 0));
    check("empty_fwft",   32'(empty_f), 32'(n == 0));
    check("almost_full",  32'(af_s),    32'(n >= AF));
    check("almost_empty", 32'(ae_s),    32'(n <= AE));
    check("overflow",     32'(ovf_s),   32'(exp_ovf));
    check("underflow",    32'(udf_s),   32'(exp_udf));
    check("ovf_fwft",     32'(ovf_f),   32'(exp_ovf));
    check("udf_fwft",     32'(udf_f),   32'(exp_udf));
    check("data_out_std", 32'(dout_s),  32'(exp_dout));
    if (n > 0) check("data_out_fwft", 32'(dout_f), 32'(q[0]));
`ifdef SYNC_FIFO_WATERMARK_EN
    check("max_count",      32'(maxc_s), 32'(peak));
    check("max_count_fwft", 32'(maxc_f), 32'(peak));
`endif
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    w_en    = w;
    data_in = d;
    r_en    = r;
    flush   = f;
    @(posedge clk);
    model_edge(w, d, r, f);
    #1;
    w_en  = 1'b0;
    r_en  = 1'b0;
    flush = 1'b0;
    compare_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = '0;
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_ae", 32'(ae_s), 32'd1);
    check("reset_af", 32'(af_s), 32'd0);
    rst_n = 1'b1;

    // Fill, overflow, drain, underflow
    for (int i = 0; i < DEP; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    check("fill_full", 32'(full_s), 32'd1);
    step(1'b1, 8'h16, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_s), 32'd1);
    for (int i = 0; i < DEP; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_order", 32'(dout_s), 32'(8'h11 + i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", 32'(udf_s), 32'd1);

    // Wrap: fill 3 / read 3, four rounds
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + rnd * 3 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Simultaneous read/write at count 2, then at full
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h6F, 1'b1, 1'b0);
    check("full_rw_count", 32'(count_s), 32'd4);

    // Flush with data and overflow pending; write in flush cycle is dropped
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_empty", 32'(empty_s), 32'd1);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_flush_data", 32'(dout_s), 32'h5A);

    // FWFT visibility
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_show", 32'(dout_f), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Async reset mid-burst
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
`ifdef SYNC_FIFO_WATERMARK_EN
    check("max_before_rst", 32'(maxc_s), 32'd4);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    model_clear(1'b1);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_rt", 32'(dout_s), 32'h3C);

    // Randomized phases: fill-biased, balanced, drain-biased
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        int wp;
        int rp;
        wp = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
        rp = 100 - wp;
        step(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom_range(0, 99) < rp),
             1'($urandom_range(0, 49) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
